// File: rtl/tt_cpu_pkg.sv
// Shared definitions for the TinyTapeout CPU wrapper: default widths,
// the program-loader FSM encoding and the loader status bit positions.
package tt_cpu_pkg;

    localparam int TT_DATA_WIDTH = 32;
    localparam int TT_WIDTH      = 8;
    localparam int TT_ADD_WIDTH  = 7;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RUN   = 2'd3
    } loader_state_t;

    localparam int STAT_WORD_PENDING = 0;
    localparam int STAT_LOADING      = 1;
    localparam int STAT_WRAP         = 2;
    localparam int STAT_FRAME_ERR    = 3;

endpackage

// File: rtl/tt_pin_sync.sv
// N-flop pin synchroniser; with EDGE set, the output is instead a one-cycle
// pulse on the synchronised rising edge (one extra flop for the edge detect).
module tt_pin_sync #(
    parameter int STAGES = 2,
    parameter bit EDGE   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic sync_out
);

    logic [STAGES-1:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= '0;
        end else begin
            sh <= {sh[STAGES-2:0], pin};
        end
    end

    if (EDGE) begin : g_edge
        logic last;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                last <= 1'b0;
            end else begin
                last <= sh[STAGES-1];
            end
        end

        assign sync_out = sh[STAGES-1] & ~last;
    end else begin : g_level
        assign sync_out = sh[STAGES-1];
    end

endmodule

// File: rtl/tt_pm_byte_loader.sv
// Byte-serial program-memory loader: assembles pin bytes little-endian into
// words, writes them at an auto-incrementing address, and taps ALU result lanes.
module tt_pm_byte_loader
    import tt_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = TT_DATA_WIDTH,
    parameter int WIDTH      = TT_WIDTH,
    parameter int ADD_WIDTH  = TT_ADD_WIDTH,
    localparam int LANES     = DATA_WIDTH / WIDTH,
    localparam int SEL_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_mode,
    input  logic                  strobe,
    input  logic                  addr_set,
    input  logic [WIDTH-1:0]      byte_in,
    input  logic [SEL_W-1:0]      lane_sel,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  pm_wr_en,
    output logic [ADD_WIDTH-1:0]  pm_addr,
    output logic [DATA_WIDTH-1:0] pm_wdata,
    output logic                  cpu_rst_n,
    output logic [WIDTH-1:0]      result_byte,
    output logic [3:0]            status
);

    logic                  load_mode_s;
    logic                  acc;
    loader_state_t         state;
    logic [ADD_WIDTH-1:0]  addr;
    logic [ADD_WIDTH-1:0]  addr_load;
    logic [SEL_W-1:0]      byte_cnt;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] word_next;
    logic [1:0]            prime;
    logic                  frame_err;
    logic                  wrap;
    logic                  loading;
    logic                  last_byte;

    tt_pin_sync #(.STAGES(2), .EDGE(1'b0)) u_load_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .pin      (load_mode),
        .sync_out (load_mode_s)
    );

    tt_pin_sync #(.STAGES(2), .EDGE(1'b1)) u_strobe_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .pin      (strobe),
        .sync_out (acc)
    );

    if (ADD_WIDTH > WIDTH) begin : g_addr_zext
        assign addr_load = {{(ADD_WIDTH - WIDTH){1'b0}}, byte_in};
    end else begin : g_addr_trunc
        assign addr_load = byte_in[ADD_WIDTH-1:0];
    end

    always_comb begin
        word_next = word;
        word_next[int'(byte_cnt) * WIDTH +: WIDTH] = byte_in;
    end

    assign last_byte = (byte_cnt == SEL_W'(LANES - 1));

    // HOLD waits for prime[1] so the synchroniser's reset value of load_mode
    // cannot release the CPU for a cycle straight after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HOLD;
            addr      <= '0;
            byte_cnt  <= '0;
            word      <= '0;
            prime     <= '0;
            frame_err <= 1'b0;
            wrap      <= 1'b0;
            loading   <= 1'b0;
            cpu_rst_n <= 1'b0;
            pm_wr_en  <= 1'b0;
            pm_addr   <= '0;
            pm_wdata  <= '0;
        end else begin
            prime    <= {prime[0], 1'b1};
            pm_wr_en <= 1'b0;
            case (state)
                ST_HOLD: begin
                    if (prime[1]) begin
                        if (load_mode_s) begin
                            state     <= ST_LOAD;
                            loading   <= 1'b1;
                            frame_err <= 1'b0;
                            wrap      <= 1'b0;
                        end else begin
                            state     <= ST_RUN;
                            cpu_rst_n <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (!load_mode_s) begin
                        state    <= ST_HOLD;
                        loading  <= 1'b0;
                        byte_cnt <= '0;
                        if (byte_cnt != '0) frame_err <= 1'b1;
                    end else if (acc) begin
                        if (addr_set) begin
                            addr     <= addr_load;
                            byte_cnt <= '0;
                            word     <= '0;
                        end else begin
                            word     <= word_next;
                            byte_cnt <= byte_cnt + 1'b1;
                            if (last_byte) begin
                                state    <= ST_WRITE;
                                pm_wr_en <= 1'b1;
                                pm_addr  <= addr;
                                pm_wdata <= word_next;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    state    <= ST_LOAD;
                    addr     <= addr + 1'b1;
                    byte_cnt <= '0;
                    if (&addr) wrap <= 1'b1;
                end
                ST_RUN: begin
                    if (load_mode_s) begin
                        state     <= ST_HOLD;
                        cpu_rst_n <= 1'b0;
                    end
                end
                default: state <= ST_HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_byte <= '0;
        end else begin
            result_byte <= alu_result[int'(lane_sel) * WIDTH +: WIDTH];
        end
    end

    always_comb begin
        status                    = '0;
        status[STAT_FRAME_ERR]    = frame_err;
        status[STAT_WRAP]         = wrap;
        status[STAT_LOADING]      = loading;
        status[STAT_WORD_PENDING] = (byte_cnt != '0);
    end

endmodule

// File: tb/tb_tt_pm_byte_loader.sv
// Bench for tt_pm_byte_loader: directed load sequences with an expected-write
// queue, plus a table of result-lane vectors.
module tb_tt_pm_byte_loader;

    localparam int DW = 32;
    localparam int BW = 8;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_mode;
    logic          strobe;
    logic          addr_set;
    logic [BW-1:0] byte_in;
    logic [1:0]    lane_sel;
    logic [DW-1:0] alu_result;
    logic          pm_wr_en;
    logic [AW-1:0] pm_addr;
    logic [DW-1:0] pm_wdata;
    logic          cpu_rst_n;
    logic [BW-1:0] result_byte;
    logic [3:0]    status;

    int n_pass  = 0;
    int n_total = 0;

    logic [AW+DW-1:0] exp_q[$];

    typedef struct {
        logic [1:0]    lane;
        logic [DW-1:0] alu;
        logic [BW-1:0] exp;
    } lane_vec_t;

    lane_vec_t lane_tab[6];

    tt_pm_byte_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_mode   (load_mode),
        .strobe      (strobe),
        .addr_set    (addr_set),
        .byte_in     (byte_in),
        .lane_sel    (lane_sel),
        .alu_result  (alu_result),
        .pm_wr_en    (pm_wr_en),
        .pm_addr     (pm_addr),
        .pm_wdata    (pm_wdata),
        .cpu_rst_n   (cpu_rst_n),
        .result_byte (result_byte),
        .status      (status)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Every wait goes through here so each write pulse is scored exactly once.
    task automatic tick();
        logic [AW+DW-1:0] e;
        @(negedge clk);
        if (pm_wr_en === 1'b1) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            check("pm_write", {pm_addr, pm_wdata}, e);
        end
    endtask

    task automatic send_byte(input logic as, input logic [BW-1:0] b);
        addr_set = as;
        byte_in  = b;
        strobe   = 1'b1;
        repeat (4) tick();
        strobe   = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        for (int i = 0; i < DW / BW; i++) send_byte(1'b0, w[i*BW +: BW]);
    endtask

    initial begin
        logic [BW-1:0] prev;

        lane_tab[0] = '{2'd0, 32'hDEADBEEF, 8'hEF};
        lane_tab[1] = '{2'd1, 32'hDEADBEEF, 8'hBE};
        lane_tab[2] = '{2'd2, 32'hDEADBEEF, 8'hAD};
        lane_tab[3] = '{2'd3, 32'hDEADBEEF, 8'hDE};
        lane_tab[4] = '{2'd2, 32'h12345678, 8'h34};
        lane_tab[5] = '{2'd1, 32'h12345678, 8'h56};

        rst_n      = 1'b0;
        load_mode  = 1'b1;
        strobe     = 1'b0;
        addr_set   = 1'b0;
        byte_in    = '0;
        lane_sel   = '0;
        alu_result = '0;

        repeat (3) tick();
        check("reset_cpu_rst_n", cpu_rst_n, 0);
        check("reset_status", status, 4'b0000);
        check("reset_wr_en", pm_wr_en, 0);
        check("reset_pm_addr", pm_addr, 0);
        check("reset_pm_wdata", pm_wdata, 0);

        rst_n = 1'b1;
        tick();
        check("hold_status", status, 4'b0000);
        check("hold_cpu_rst_n", cpu_rst_n, 0);
        repeat (3) tick();
        check("load_entry_status", status, 4'b0010);
        check("load_entry_cpu_rst_n", cpu_rst_n, 0);

        exp_q.push_back({7'd0, 32'h00100513});
        send_byte(1'b0, 8'h13);
        send_byte(1'b0, 8'h05);
        send_byte(1'b0, 8'h10);
        send_byte(1'b0, 8'h00);
        check("word0_written", exp_q.size(), 0);
        check("after_word0_status", status, 4'b0010);

        exp_q.push_back({7'd1, 32'hDDCCBBAA});
        send_byte(1'b0, 8'hAA);
        check("pending_status", status, 4'b0011);
        send_byte(1'b0, 8'hBB);
        send_byte(1'b0, 8'hCC);
        send_byte(1'b0, 8'hDD);
        check("word1_written", exp_q.size(), 0);

        send_byte(1'b1, 8'h7F);
        check("addr_set_status", status, 4'b0010);
        exp_q.push_back({7'h7F, 32'h04030201});
        exp_q.push_back({7'h00, 32'h08070605});
        for (int i = 1; i <= 8; i++) send_byte(1'b0, 8'(i));
        check("wrap_words_written", exp_q.size(), 0);
        check("wrap_status", status, 4'b0110);

        send_byte(1'b0, 8'h11);
        send_byte(1'b0, 8'h22);
        check("partial_status", status, 4'b0111);
        load_mode = 1'b0;
        repeat (6) tick();
        check("frame_err_status", status, 4'b1100);
        check("run_cpu_rst_n", cpu_rst_n, 1);

        prev = '0;
        for (int i = 0; i < 6; i++) begin
            lane_sel   = lane_tab[i].lane;
            alu_result = lane_tab[i].alu;
            #1;
            check("lane_latency", result_byte, prev);
            tick();
            check("lane_value", result_byte, lane_tab[i].exp);
            prev = lane_tab[i].exp;
        end

        load_mode = 1'b1;
        repeat (6) tick();
        check("reload_status", status, 4'b0010);
        check("reload_cpu_rst_n", cpu_rst_n, 0);

        send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'h02);
        send_byte(1'b0, 8'h03);
        check("mid_word_status", status, 4'b0011);
        rst_n = 1'b0;
        #1;
        check("async_rst_cpu_rst_n", cpu_rst_n, 0);
        check("async_rst_wr_en", pm_wr_en, 0);
        check("async_rst_status", status, 4'b0000);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_reset_status", status, 4'b0010);

        exp_q.push_back({7'd0, 32'hCAFEF00D});
        send_word(32'hCAFEF00D);
        check("post_reset_word_written", exp_q.size(), 0);
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
